// File: rtl/btn_pkg.sv
// Shared definitions for the button press classifier: FSM state encoding
// and the default timing constants.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PRESSED  = 2'b01,
    ST_LONG     = 2'b10,
    ST_WAIT_REL = 2'b11
  } btn_state_e;

  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;
  localparam int unsigned DEF_CNT_W         = 26;

endpackage

// File: rtl/btn_press_classifier_timer.sv
// Hold-duration counter with synchronous clear, count enable and a
// terminal-count compare against a caller-supplied value.
module cycle_timer #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; the counter never wraps because the owner clears at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/btn_press_classifier.sv
// Classifies a debounced button level into one-cycle press, short-release,
// long-hold and auto-repeat pulses, suppressing presses held across reset.
module btn_press_classifier
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       deb_in,
  output logic       press_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [1:0] state_out
);

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_e       state_q, state_d;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             tmr_clr_s, tmr_en_s, tmr_tc_s;
  logic [CNT_W-1:0] tc_val_s;

  assign tc_val_s = (state_q == ST_LONG) ? REPEAT_TC : LONG_TC;

  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tmr_clr_s),
    .en_i     (tmr_en_s),
    .tc_val_i (tc_val_s),
    .tc_o     (tmr_tc_s)
  );

  // Release is tested before terminal count so it wins any coincidence.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    tmr_clr_s = 1'b0;
    tmr_en_s  = 1'b0;
    case (state_q)
      ST_WAIT_REL: begin
        if (!deb_in) state_d = ST_IDLE;
        else         state_d = ST_WAIT_REL;
      end
      ST_IDLE: begin
        if (deb_in) begin
          state_d   = ST_PRESSED;
          press_d   = 1'b1;
          tmr_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (!deb_in) begin
          state_d   = ST_IDLE;
          short_d   = 1'b1;
          tmr_clr_s = 1'b1;
        end else if (tmr_tc_s) begin
          state_d   = ST_LONG;
          long_d    = 1'b1;
          tmr_clr_s = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_LONG: begin
        if (!deb_in) begin
          state_d   = ST_IDLE;
          tmr_clr_s = 1'b1;
        end else if (tmr_tc_s) begin
          repeat_d  = 1'b1;
          tmr_clr_s = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT_REL;
      end
    endcase
  end

  // Reset lands in WAIT_REL so a button held through reset must be released first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_WAIT_REL;
      press_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      press_q  <= press_d;
      short_q  <= short_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
    end
  end

  assign press_pulse  = press_q;
  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign held         = (state_q == ST_PRESSED) || (state_q == ST_LONG);
  assign state_out    = state_q;

endmodule
